nipcb_spi_arbiter: RTL and testbench
====================================

Name: nipcb_spi_arbiter

Overview:
- Shares the single two-slave SPI master (slave 0 = HP DAC write, slave 1 = ADC read) between the stimulation and recording sequencers inside the NIPCB peripheral.
- Replaces ad-hoc cross-checks between the two sequencers with a request/grant handshake.
- Stimulation has fixed priority; a starvation guard and a hard recording block (stimulation window) apply.
- Sits between the sequencers and spi_core and drives its send/recv/odata directly.

Parameters:
O_BW, 16, SPI transmit word width (DAC frame)
I_BW, 14, SPI receive word width (ADC sample)
STARVE_LIMIT, 4, consecutive stim grants allowed while an eligible rec request waits; range 1..255
START_TO, 8, cycles to wait for spi_ready to fall after issue before flagging an error; minimum 2

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
stim_req  in  1  level; held until stim_gnt
stim_wdata  in  O_BW  DAC frame; sampled on the grant cycle
stim_gnt  out  1  1-cycle pulse; transfer issued
stim_done  out  1  1-cycle pulse; DAC frame fully shifted
rec_req  in  1  level; held until rec_gnt
rec_block  in  1  1 = stimulation window active; recording must not be granted
rec_gnt  out  1  1-cycle pulse; ADC read issued
rec_done  out  1  1-cycle pulse; rec_rdata valid this cycle
rec_rdata  out  I_BW  captured ADC sample; held until next rec_done
spi_odata  out  O_BW  to spi_core odata
spi_send  out  2  to spi_core send; one-hot, only bit 0 used
spi_recv  out  2  to spi_core recv; one-hot, only bit 1 used
spi_idata  in  I_BW  from spi_core idata
spi_ready  in  1  from spi_core; 1 = idle
busy  out  1  1 from grant until done or error
owner  out  1  0 = stim, 1 = rec; valid while busy
err  out  1  1-cycle pulse; start timeout

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous, active-low.
- Reset values: all outputs 0 (spi_odata, rec_rdata, counters included), state IDLE.
- Reset mid-transfer: abandon the transfer with no done pulse; spi_core shares rstn.
- States: IDLE, START, XFER.
- IDLE: arbitrate only when spi_ready = 1.
  - rec_elig = rec_req & ~rec_block.
  - Stim wins if stim_req & ~(rec_elig & starve_cnt == STARVE_LIMIT).
  - Otherwise rec wins if rec_elig.
  - On a win, registered outputs next cycle: gnt pulse, spi_send[0] or spi_recv[1] pulse, busy = 1, owner set, state -> START.
  - Latency: req seen in IDLE -> gnt/send one cycle later.
- Stim grant:
  - Latch stim_wdata into spi_odata.
  - spi_odata stays stable until the next stim grant. Rec transfers do not alter it; spi_core ignores odata on recv.
- START: wait for spi_ready = 0, then -> XFER. Count cycles.
  - If the count reaches START_TO: err pulse, busy = 0, no done pulse, state -> IDLE.
- XFER: on spi_ready = 1, done pulse for owner, busy = 0, state -> IDLE.
  - If owner = rec: rec_rdata <= spi_idata in the same cycle as rec_done.
- No back-to-back grants: at least one IDLE cycle between done/err and the next gnt.
- starve_cnt (8 bit, saturating):
  - +1 on each stim grant while rec_elig = 1.
  - Cleared on rec grant, and cleared in any IDLE cycle where rec_elig = 0.
- rec_block:
  - Overrides starvation; rec is never granted while rec_block = 1.
  - rec_block rising during an active rec transfer does not abort it.
- Request drop: a req dropped before gnt is simply not served; a req dropped after gnt has no effect.
- Simultaneous stim_req and rec_elig with starve_cnt < STARVE_LIMIT: stim granted.
- spi_send and spi_recv are never both non-zero. Unused bits (spi_send[1], spi_recv[0]) are tied 0.

Decomposition:
- Shared package nipcb_pkg holds:
  - state encoding localparams (ARB_IDLE, ARB_START, ARB_XFER)
  - slave indices SLV_DAC = 0, SLV_ADC = 1
  - owner codes OWN_STIM = 0, OWN_REC = 1
  - default widths 16/14
- Single module; no sub-module. The starvation counter and timeout counter are inline.

Test Plan:
1. Stim only: stim_req = 1, stim_wdata = 16'h03F8, spi model ready low 16 cycles -> stim_gnt and spi_send = 2'b01 one cycle after req; spi_odata = 16'h03F8; stim_done 1 cycle after ready rises; spi_recv stays 0.
2. Rec only: rec_req = 1, rec_block = 0, model returns idata = 14'h1ABC -> rec_gnt with spi_recv = 2'b10; rec_done with rec_rdata = 14'h1ABC; owner = 1 while busy.
3. Contention and starvation: stim_req and rec_req held high, STARVE_LIMIT = 4 -> grant order S,S,S,S,R,S,S,S,S,R; starve_cnt returns to 0 after each R.
4. Block: rec_req = 1, rec_block = 1 for 50 cycles, stim_req = 0 -> no rec_gnt and busy = 0; rec_block drops -> rec_gnt in 1 cycle. rec_block rising mid-XFER -> rec_done still issued.
5. Timeout: spi_ready stuck at 1 after a stim grant, START_TO = 8 -> err pulse exactly 8 cycles after gnt, no stim_done, returns to IDLE, re-grants on the next req.
6. Async reset: drop rstn mid-XFER between clock edges -> all outputs 0 immediately, no done pulse; after release, stim_req is served normally.

Source files
------------

// File: rtl/nipcb_pkg.sv
// nipcb_pkg: shared encodings for the NIPCB SPI arbiter.
package nipcb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_START, ARB_XFER} arb_state_t;
  localparam int SLV_DAC = 0;
  localparam int SLV_ADC = 1;
  localparam logic OWN_STIM = 1'b0;
  localparam logic OWN_REC = 1'b1;
  localparam int DEF_O_BW = 16;
  localparam int DEF_I_BW = 14;
endpackage

// File: rtl/nipcb_spi_arbiter.sv
// nipcb_spi_arbiter: request/grant arbiter sharing one SPI master between the stim (DAC write)
// and rec (ADC read) sequencers, with stim priority, a starvation guard and a rec block window.
module nipcb_spi_arbiter
  import nipcb_pkg::*;
#(
  parameter int O_BW = DEF_O_BW,
  parameter int I_BW = DEF_I_BW,
  parameter int STARVE_LIMIT = 4,
  parameter int START_TO = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stim_req,
  input  logic [O_BW-1:0] stim_wdata,
  output logic            stim_gnt,
  output logic            stim_done,
  input  logic            rec_req,
  input  logic            rec_block,
  output logic            rec_gnt,
  output logic            rec_done,
  output logic [I_BW-1:0] rec_rdata,
  output logic [O_BW-1:0] spi_odata,
  output logic [1:0]      spi_send,
  output logic [1:0]      spi_recv,
  input  logic [I_BW-1:0] spi_idata,
  input  logic            spi_ready,
  output logic            busy,
  output logic            owner,
  output logic            err
);
  localparam int TW = $clog2(START_TO + 1);
  arb_state_t state;
  logic [7:0] starve_cnt;
  logic [TW-1:0] to_cnt;
  logic rec_elig, starved, arb, stim_win, rec_win;
  assign rec_elig = rec_req & ~rec_block;
  assign starved = rec_elig & (starve_cnt == 8'(STARVE_LIMIT));
  // the IDLE cycle carrying a done/err pulse never arbitrates, forcing a gap before the next grant
  assign arb = (state == ARB_IDLE) & spi_ready & ~(stim_done | rec_done | err);
  assign stim_win = arb & stim_req & ~starved;
  assign rec_win = arb & rec_elig & ~stim_win;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= ARB_IDLE;
      starve_cnt <= '0;
      to_cnt <= '0;
      stim_gnt <= 1'b0;
      stim_done <= 1'b0;
      rec_gnt <= 1'b0;
      rec_done <= 1'b0;
      rec_rdata <= '0;
      spi_odata <= '0;
      spi_send <= '0;
      spi_recv <= '0;
      busy <= 1'b0;
      owner <= 1'b0;
      err <= 1'b0;
    end else begin
      stim_gnt <= stim_win;
      rec_gnt <= rec_win;
      spi_send <= '0;
      spi_send[SLV_DAC] <= stim_win;
      spi_recv <= '0;
      spi_recv[SLV_ADC] <= rec_win;
      stim_done <= 1'b0;
      rec_done <= 1'b0;
      err <= 1'b0;
      if (stim_win) spi_odata <= stim_wdata;
      if (rec_win || (state == ARB_IDLE && !rec_elig)) starve_cnt <= '0;
      else if (stim_win && rec_elig && starve_cnt != 8'hFF) starve_cnt <= starve_cnt + 8'd1;
      case (state)
        ARB_IDLE:
          if (stim_win || rec_win) begin
            state <= ARB_START;
            busy <= 1'b1;
            owner <= rec_win ? OWN_REC : OWN_STIM;
            to_cnt <= '0;
          end
        ARB_START:
          if (!spi_ready) state <= ARB_XFER;
          else if (to_cnt == TW'(START_TO - 1)) begin
            err <= 1'b1;
            busy <= 1'b0;
            state <= ARB_IDLE;
          end else to_cnt <= to_cnt + TW'(1);
        ARB_XFER:
          if (spi_ready) begin
            stim_done <= owner == OWN_STIM;
            rec_done <= owner == OWN_REC;
            if (owner == OWN_REC) rec_rdata <= spi_idata;
            busy <= 1'b0;
            state <= ARB_IDLE;
          end
        default: state <= ARB_IDLE;
      endcase
    end
endmodule

// File: tb/tb_nipcb_spi_arbiter.sv
// tb_nipcb_spi_arbiter: randomized self-checking bench with a behavioural SPI slave
// and a transaction-level arbitration model.
module tb_nipcb_spi_arbiter;
  localparam int O_BW = 16;
  localparam int I_BW = 14;
  localparam int LIM = 4;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic stim_req = 1'b0, rec_req = 1'b0, rec_block = 1'b0;
  logic [O_BW-1:0] stim_wdata = '0;
  logic [I_BW-1:0] spi_idata = '0;
  logic spi_ready = 1'b1;
  logic stim_gnt, stim_done, rec_gnt, rec_done, busy, owner, err;
  logic [I_BW-1:0] rec_rdata;
  logic [O_BW-1:0] spi_odata;
  logic [1:0] spi_send, spi_recv;
  int errors = 0, checks = 0;
  int spi_len = 4, spi_cnt = 0;
  logic spi_stuck = 1'b0;
  int n_sd = 0, n_rd = 0, n_rcv = 0, n_bad = 0;
  logic [O_BW-1:0] last_odata = '0;

  nipcb_spi_arbiter #(.O_BW(O_BW), .I_BW(I_BW), .STARVE_LIMIT(LIM), .START_TO(TO)) dut (
    .clk(clk), .rstn(rstn),
    .stim_req(stim_req), .stim_wdata(stim_wdata), .stim_gnt(stim_gnt), .stim_done(stim_done),
    .rec_req(rec_req), .rec_block(rec_block), .rec_gnt(rec_gnt), .rec_done(rec_done),
    .rec_rdata(rec_rdata), .spi_odata(spi_odata), .spi_send(spi_send), .spi_recv(spi_recv),
    .spi_idata(spi_idata), .spi_ready(spi_ready), .busy(busy), .owner(owner), .err(err)
  );

  always #5 clk = ~clk;

  // SPI slave: ready falls the cycle after a strobe and stays low for spi_len cycles
  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      spi_ready <= 1'b1;
      spi_cnt <= 0;
    end else if ((spi_send[0] | spi_recv[1]) && !spi_stuck) begin
      spi_ready <= 1'b0;
      spi_cnt <= spi_len;
    end else if (!spi_ready) begin
      if (spi_cnt <= 1) spi_ready <= 1'b1;
      spi_cnt <= spi_cnt - 1;
    end

  always @(negedge clk)
    if (rstn) begin
      n_sd <= n_sd + (stim_done ? 1 : 0);
      n_rd <= n_rd + (rec_done ? 1 : 0);
      n_rcv <= n_rcv + (|spi_recv ? 1 : 0);
      n_bad <= n_bad + (((|spi_send && |spi_recv) || spi_send[1] || spi_recv[0]) ? 1 : 0);
    end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ev(input int w);
    return w == 0 ? stim_done : w == 1 ? rec_done : w == 2 ? err : (stim_gnt | rec_gnt);
  endfunction

  // returns the number of ticks until the event, or -1 if it never came
  task automatic wait_ev(input int w, input int lim, output int k);
    k = -1;
    for (int i = 1; i <= lim && k < 0; i++) begin
      tick();
      if (ev(w)) k = i;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({stim_gnt, stim_done, rec_gnt, rec_done, busy, owner, err, spi_send, spi_recv, spi_odata, rec_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b%b done=%b%b busy=%b owner=%b err=%b send=%b recv=%b odata=%h rdata=%h, want all 0",
               stim_gnt, rec_gnt, stim_done, rec_done, busy, owner, err, spi_send, spi_recv, spi_odata, rec_rdata);
    end
    rstn = 1'b1;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || stim_gnt !== 1'b0 || rec_gnt !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b gnt=%b%b, want 0 00", busy, stim_gnt, rec_gnt);
    end
  endtask

  task automatic test_stim(input logic [O_BW-1:0] d, input int len);
    int k, r0;
    r0 = n_rcv;
    stim_wdata = d;
    spi_len = len;
    stim_req = 1'b1;
    tick();
    stim_req = 1'b0;
    checks++;
    if ({stim_gnt, rec_gnt, spi_send, spi_odata, busy, owner} !== {1'b1, 1'b0, 2'b01, d, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL stim_grant: got gnt=%b%b send=%b odata=%h busy=%b owner=%b, want 10 01 %h 1 0",
               stim_gnt, rec_gnt, spi_send, spi_odata, busy, owner, d);
    end
    last_odata = d;
    wait_ev(0, len + 20, k);
    checks++;
    if (k != len + 2) begin
      errors++;
      $display("FAIL stim_done_latency: got %0d cycles after gnt, want %0d", k, len + 2);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || n_rcv != r0) begin
      errors++;
      $display("FAIL stim_after: got busy=%b recv_strobes=%0d, want 0 0", busy, n_rcv - r0);
    end
    tick();
  endtask

  task automatic test_rec(input logic [I_BW-1:0] d, input int len);
    int k;
    spi_idata = d;
    spi_len = len;
    rec_block = 1'b0;
    rec_req = 1'b1;
    tick();
    rec_req = 1'b0;
    checks++;
    if ({rec_gnt, stim_gnt, spi_recv, spi_send, busy, owner, spi_odata} !== {1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, last_odata}) begin
      errors++;
      $display("FAIL rec_grant: got gnt=%b%b recv=%b send=%b busy=%b owner=%b odata=%h, want 10 10 00 1 1 %h",
               rec_gnt, stim_gnt, spi_recv, spi_send, busy, owner, spi_odata, last_odata);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || owner !== 1'b1) begin
      errors++;
      $display("FAIL rec_owner: got busy=%b owner=%b, want 1 1", busy, owner);
    end
    wait_ev(1, len + 20, k);
    checks++;
    if (k != len + 1 || rec_rdata !== d) begin
      errors++;
      $display("FAIL rec_done: got latency=%0d rdata=%h, want %0d %h", k + 1, rec_rdata, len + 2, d);
    end
    spi_idata = ~d;
    repeat (2) tick();
    checks++;
    if (rec_rdata !== d || busy !== 1'b0) begin
      errors++;
      $display("FAIL rec_hold: got rdata=%h busy=%b, want %h 0", rec_rdata, busy, d);
    end
  endtask

  task automatic test_starve();
    int cnt = 0, seen = 0, k = 0, last_done = -100;
    logic exp_rec;
    stim_req = 1'b1;
    rec_req = 1'b1;
    rec_block = 1'b0;
    while (seen < 10 && k < 1000) begin
      spi_len = $urandom_range(1, 5);
      stim_wdata = O_BW'($urandom);
      tick();
      k++;
      if (stim_done || rec_done) last_done = k;
      if (stim_gnt || rec_gnt) begin
        exp_rec = (cnt == LIM);
        cnt = exp_rec ? 0 : cnt + 1;
        checks++;
        if (rec_gnt !== exp_rec || stim_gnt === rec_gnt || (!exp_rec && spi_odata !== stim_wdata)) begin
          errors++;
          $display("FAIL starve_order: grant %0d got stim=%b rec=%b odata=%h, want rec=%b odata=%h",
                   seen, stim_gnt, rec_gnt, spi_odata, exp_rec, stim_wdata);
        end
        if (!exp_rec) last_odata = stim_wdata;
        if (seen > 0) begin
          checks++;
          if (k - last_done != 2) begin
            errors++;
            $display("FAIL grant_gap: grant %0d got %0d cycles after done, want 2", seen, k - last_done);
          end
        end
        seen++;
      end
    end
    stim_req = 1'b0;
    rec_req = 1'b0;
    checks++;
    if (seen < 10) begin
      errors++;
      $display("FAIL starve_timeout: got %0d grants, want 10", seen);
    end
    for (int i = 0; i < 50 && busy; i++) tick();
    repeat (2) tick();
  endtask

  task automatic test_block();
    int k, g = 0;
    logic [I_BW-1:0] d;
    stim_req = 1'b0;
    rec_req = 1'b1;
    rec_block = 1'b1;
    repeat (50) begin
      tick();
      if (rec_gnt || busy) g++;
    end
    checks++;
    if (g != 0) begin
      errors++;
      $display("FAIL block_hold: got %0d cycles with grant/busy, want 0", g);
    end
    d = I_BW'($urandom);
    spi_idata = d;
    spi_len = 10;
    rec_block = 1'b0;
    tick();
    rec_req = 1'b0;
    checks++;
    if (rec_gnt !== 1'b1 || spi_recv !== 2'b10) begin
      errors++;
      $display("FAIL block_release: got gnt=%b recv=%b, want 1 10", rec_gnt, spi_recv);
    end
    repeat (4) tick();
    rec_block = 1'b1;
    wait_ev(1, 30, k);
    checks++;
    if (k != 8 || rec_rdata !== d) begin
      errors++;
      $display("FAIL block_midxfer: got done after %0d rdata=%h, want 8 %h", k, rec_rdata, d);
    end
    rec_block = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    int k, s0;
    logic [O_BW-1:0] d;
    s0 = n_sd;
    spi_stuck = 1'b1;
    d = O_BW'($urandom);
    stim_wdata = d;
    stim_req = 1'b1;
    tick();
    stim_req = 1'b0;
    checks++;
    if (stim_gnt !== 1'b1 || spi_odata !== d) begin
      errors++;
      $display("FAIL timeout_grant: got gnt=%b odata=%h, want 1 %h", stim_gnt, spi_odata, d);
    end
    last_odata = d;
    wait_ev(2, 30, k);
    checks++;
    if (k != TO) begin
      errors++;
      $display("FAIL err_latency: got %0d cycles after gnt, want %0d", k, TO);
    end
    checks++;
    if (busy !== 1'b0 || n_sd != s0 || stim_done !== 1'b0) begin
      errors++;
      $display("FAIL err_state: got busy=%b stim_done_count=%0d, want 0 0", busy, n_sd - s0);
    end
    spi_stuck = 1'b0;
    spi_len = 3;
    d = O_BW'($urandom);
    stim_wdata = d;
    stim_req = 1'b1;
    wait_ev(3, 10, k);
    stim_req = 1'b0;
    checks++;
    if (k != 2 || stim_gnt !== 1'b1 || spi_odata !== d) begin
      errors++;
      $display("FAIL err_regrant: got gnt after %0d stim_gnt=%b odata=%h, want 2 1 %h", k, stim_gnt, spi_odata, d);
    end
    last_odata = d;
    wait_ev(0, 20, k);
    checks++;
    if (k != 5) begin
      errors++;
      $display("FAIL err_regrant_done: got %0d, want 5", k);
    end
    repeat (2) tick();
  endtask

  task automatic test_async_reset();
    int k, s0;
    logic [O_BW-1:0] d;
    spi_len = 10;
    stim_wdata = O_BW'($urandom);
    stim_req = 1'b1;
    tick();
    stim_req = 1'b0;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got busy=%b, want 1", busy);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({stim_gnt, stim_done, rec_gnt, rec_done, busy, owner, err, spi_send, spi_recv, spi_odata, rec_rdata} !== '0) begin
      errors++;
      $display("FAIL areset_outputs: got busy=%b done=%b%b send=%b odata=%h rdata=%h, want all 0",
               busy, stim_done, rec_done, spi_send, spi_odata, rec_rdata);
    end
    s0 = n_sd;
    repeat (3) tick();
    rstn = 1'b1;
    repeat (12) tick();
    checks++;
    if (n_sd != s0 || busy !== 1'b0 || spi_odata !== '0) begin
      errors++;
      $display("FAIL areset_abandon: got done_count=%0d busy=%b odata=%h, want 0 0 0", n_sd - s0, busy, spi_odata);
    end
    d = O_BW'($urandom);
    stim_wdata = d;
    spi_len = 3;
    stim_req = 1'b1;
    tick();
    stim_req = 1'b0;
    checks++;
    if (stim_gnt !== 1'b1 || spi_send !== 2'b01 || spi_odata !== d) begin
      errors++;
      $display("FAIL areset_regrant: got gnt=%b send=%b odata=%h, want 1 01 %h", stim_gnt, spi_send, spi_odata, d);
    end
    last_odata = d;
    wait_ev(0, 20, k);
    checks++;
    if (k != 5) begin
      errors++;
      $display("FAIL areset_done: got %0d, want 5", k);
    end
    repeat (2) tick();
  endtask

  // transaction-level model: requests are re-chosen each round while the previous transfer runs
  task automatic test_random(input int n);
    int cnt = 0, kind = 0, plen = 0, k, w;
    logic s, r, b, elig;
    logic [I_BW-1:0] pidata = '0;
    for (int i = 0; i < n; i++) begin
      s = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 4) != 0;
      b = $urandom_range(0, 4) == 0;
      stim_req = s;
      rec_req = r;
      rec_block = b;
      stim_wdata = O_BW'($urandom);
      if (kind != 0) begin
        wait_ev(kind - 1, plen + 20, k);
        checks++;
        if (k != plen + 2 || (kind == 2 && rec_rdata !== pidata)) begin
          errors++;
          $display("FAIL rand_done: round %0d kind=%0d got latency=%0d rdata=%h, want %0d %h",
                   i, kind, k, rec_rdata, plen + 2, pidata);
        end
        spi_idata = I_BW'($urandom);
        spi_len = $urandom_range(1, 6);
        tick();
        checks++;
        if (stim_gnt || rec_gnt) begin
          errors++;
          $display("FAIL rand_gap: round %0d got grant in cycle after done, want none", i);
        end
      end else begin
        spi_idata = I_BW'($urandom);
        spi_len = $urandom_range(1, 6);
      end
      tick();
      elig = r & ~b;
      if (!elig) cnt = 0;
      w = (s && !(elig && cnt == LIM)) ? 1 : elig ? 2 : 0;
      if (w == 1 && elig && cnt < 255) cnt++;
      if (w == 2) cnt = 0;
      checks++;
      if ({stim_gnt, rec_gnt} !== {w == 1, w == 2} ||
          (w == 1 && (spi_send !== 2'b01 || spi_odata !== stim_wdata || owner !== 1'b0)) ||
          (w == 2 && (spi_recv !== 2'b10 || spi_odata !== last_odata || owner !== 1'b1))) begin
        errors++;
        $display("FAIL rand_grant: round %0d s=%b r=%b b=%b got gnt=%b%b send=%b recv=%b owner=%b odata=%h, want winner=%0d",
                 i, s, r, b, stim_gnt, rec_gnt, spi_send, spi_recv, owner, spi_odata, w);
      end
      if (w == 1) last_odata = stim_wdata;
      kind = w;
      plen = spi_len;
      pidata = spi_idata;
    end
    stim_req = 1'b0;
    rec_req = 1'b0;
    rec_block = 1'b0;
    if (kind != 0) begin
      wait_ev(kind - 1, plen + 20, k);
      checks++;
      if (k != plen + 2 || (kind == 2 && rec_rdata !== pidata)) begin
        errors++;
        $display("FAIL rand_drain: got latency=%0d rdata=%h, want %0d %h", k, rec_rdata, plen + 2, pidata);
      end
    end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_stim(16'h03F8, 16);
    repeat (3) test_stim(O_BW'($urandom), $urandom_range(1, 8));
    test_rec(14'h1ABC, 6);
    repeat (3) test_rec(I_BW'($urandom), $urandom_range(1, 8));
    test_starve();
    test_block();
    test_timeout();
    test_async_reset();
    test_random(80);
    checks++;
    if (n_bad != 0) begin
      errors++;
      $display("FAIL strobe_exclusive: got %0d bad send/recv cycles, want 0", n_bad);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
